// File: rtl/csr_intr_ctrl_if.sv
// rtl/csr_intr_ctrl_if.sv - CSR access bus between execute stage and csr_intr_ctrl
interface csr_intr_ctrl_if;
  logic        csr_wr_i;
  logic [11:0] addr_i;
  logic [1:0]  mode_sel_i;
  logic        immed_sel_i;
  logic [4:0]  immed_i;
  logic [31:0] rs1_i;
  logic [31:0] csr_data_o;

  modport master (
    output csr_wr_i, addr_i, mode_sel_i, immed_sel_i, immed_i, rs1_i,
    input  csr_data_o
  );

  modport slave (
    input  csr_wr_i, addr_i, mode_sel_i, immed_sel_i, immed_i, rs1_i,
    output csr_data_o
  );
endinterface

// File: rtl/csr_intr_ctrl.sv
// rtl/csr_intr_ctrl.sv - M-mode trap CSRs, prioritised interrupt arbiter and trap/mret sequencer
module csr_intr_ctrl #(
  parameter int NUM_IRQ      = 4,
  parameter int FLUSH_CYCLES = 3,
  parameter int VECTORED_EN  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  csr_intr_ctrl_if.slave     csr,
  input  logic               timer_intr_i,
  input  logic [NUM_IRQ-1:0] ext_irq_i,
  input  logic               stall_i,
  input  logic               hold_i,
  input  logic               mret_i,
  input  logic               pc_redirect_i,
  input  logic [31:0]        next_pc_i,
  output logic               flush_o,
  output logic [31:0]        pc_intr_addr_o,
  output logic               pc_intr_sel_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               busy_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTER, HANDLER} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          mstatus_mie, mstatus_mpie;
  logic [31:0]   mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0]   mcycle_q;

  logic [31:0]        mstatus_rd, mtvec_rd, mepc_rd, mip, rdata, wdata, wr_val;
  logic               csr_we;
  logic               irq_found;
  logic [4:0]         irq_cause;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [31:0]        trap_base, trap_target;
  logic               vec_mode, enter_sel, mret_go;

  assign mstatus_rd = {24'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
  assign mtvec_rd   = (VECTORED_EN != 0) ? mtvec_q : (mtvec_q & ~32'h3);
  assign mepc_rd    = mepc_q & ~32'h3;

  // Live pending view: timer, any-external summary, then one bit per line
  always_comb begin
    mip                  = '0;
    mip[7]               = timer_intr_i;
    mip[11]              = |ext_irq_i;
    mip[16 +: NUM_IRQ]   = ext_irq_i;
  end

  // Lowest-index enabled external line wins, timer only when no external line is eligible
  always_comb begin
    irq_found  = 1'b0;
    irq_cause  = '0;
    irq_onehot = '0;
    if (mstatus_mie) begin
      for (int k = 0; k < NUM_IRQ; k++) begin
        if (!irq_found && ext_irq_i[k] && mie_q[11] && mie_q[16+k]) begin
          irq_found     = 1'b1;
          irq_cause     = 5'(16 + k);
          irq_onehot[k] = 1'b1;
        end
      end
      if (!irq_found && timer_intr_i && mie_q[7]) begin
        irq_found = 1'b1;
        irq_cause = 5'd7;
      end
    end
  end

  // Combinational CSR read of the addressed register
  always_comb begin
    case (csr.addr_i)
      ADDR_MSTATUS:  rdata = mstatus_rd;
      ADDR_MIE:      rdata = mie_q;
      ADDR_MTVEC:    rdata = mtvec_rd;
      ADDR_MSCRATCH: rdata = mscratch_q;
      ADDR_MEPC:     rdata = mepc_rd;
      ADDR_MCAUSE:   rdata = mcause_q;
      ADDR_MIP:      rdata = mip;
      ADDR_MCYCLE:   rdata = mcycle_q[31:0];
      ADDR_MCYCLEH:  rdata = mcycle_q[63:32];
      default:       rdata = '0;
    endcase
  end
  assign csr.csr_data_o = rdata;

  // Write/set/clear result is computed from the current read value of the addressed CSR
  always_comb begin
    wdata  = csr.immed_sel_i ? {27'b0, csr.immed_i} : csr.rs1_i;
    csr_we = csr.csr_wr_i && (csr.mode_sel_i != 2'b00);
    case (csr.mode_sel_i)
      2'b01:   wr_val = wdata;
      2'b10:   wr_val = rdata | wdata;
      2'b11:   wr_val = rdata & ~wdata;
      default: wr_val = rdata;
    endcase
  end

  assign trap_base   = {mtvec_rd[31:2], 2'b00};
  assign vec_mode    = (VECTORED_EN != 0) && (mtvec_rd[1:0] == 2'b01);
  assign trap_target = vec_mode ? (trap_base + {25'b0, mcause_q[4:0], 2'b00}) : trap_base;

  assign enter_sel      = (state_q == ENTER) && (cnt_q == '0);
  assign mret_go        = (state_q == HANDLER) && mret_i;
  assign flush_o        = !rst_i && (state_q == ENTER) && (cnt_q == CNT_INIT);
  assign pc_intr_sel_o  = !rst_i && (enter_sel || mret_go);
  assign pc_intr_addr_o = !pc_intr_sel_o ? 32'b0 : (mret_go ? mepc_rd : trap_target);
  assign busy_o         = (state_q != IDLE);

  // Trap FSM; trap-take and mret updates are written last so they override same-cycle CSR writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      irq_ack_o    <= '0;
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
    end else begin
      irq_ack_o <= '0;
      if (csr_we && csr.addr_i == ADDR_MSTATUS) begin
        mstatus_mie  <= wr_val[3];
        mstatus_mpie <= wr_val[7];
      end
      if (csr_we && csr.addr_i == ADDR_MEPC && state_q != ENTER)
        mepc_q <= wr_val;
      if (csr_we && csr.addr_i == ADDR_MCAUSE && state_q != ENTER)
        mcause_q <= wr_val;
      case (state_q)
        IDLE: begin
          if (irq_found) begin
            mepc_q       <= next_pc_i;
            mcause_q     <= {1'b1, 26'b0, irq_cause};
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            cnt_q        <= CNT_INIT;
            irq_ack_o    <= irq_onehot;
            state_q      <= ENTER;
          end
        end
        ENTER: begin
          if (pc_redirect_i)
            mepc_q <= next_pc_i;
          if (!stall_i) begin
            if (cnt_q != '0)
              cnt_q <= cnt_q - CW'(1);
            else if (!hold_i)
              state_q <= HANDLER;
          end
        end
        HANDLER: begin
          if (mret_i) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Plain read/write CSRs, accepted in every state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else if (csr_we) begin
      case (csr.addr_i)
        ADDR_MIE:      mie_q      <= wr_val;
        ADDR_MTVEC:    mtvec_q    <= wr_val;
        ADDR_MSCRATCH: mscratch_q <= wr_val;
        default: ;
      endcase
    end
  end

  // Free-running cycle counter; a half being written skips that cycle's increment
  always_ff @(posedge clk_i) begin
    if (rst_i)
      mcycle_q <= '0;
    else if (csr_we && csr.addr_i == ADDR_MCYCLE)
      mcycle_q[31:0] <= wr_val;
    else if (csr_we && csr.addr_i == ADDR_MCYCLEH)
      mcycle_q[63:32] <= wr_val;
    else
      mcycle_q <= mcycle_q + 64'd1;
  end

endmodule
